// File: rtl/apu_pkg.sv
// Shared APU definitions: default channel widths, register byte addresses
// and the length-counter load table used by every channel.
package apu_pkg;

    localparam int unsigned TIMER_W_DEF = 11;
    localparam int unsigned LIN_W_DEF   = 7;
    localparam int unsigned LEN_W_DEF   = 8;
    localparam int unsigned OUT_W_DEF   = 4;
    localparam int unsigned LEN_IDX_W   = 5;

    localparam logic [1:0] REG_LINEAR   = 2'd0;
    localparam logic [1:0] REG_TIMER_LO = 2'd2;
    localparam logic [1:0] REG_TIMER_HI = 2'd3;

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/apu_triangle_channel_if.sv
// Byte-wide register write port into an APU channel.
interface apu_triangle_channel_if;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;

    modport master (output reg_we, output reg_addr, output reg_wdata);
    modport slave  (input  reg_we, input  reg_addr, input  reg_wdata);
endinterface

// File: rtl/apu_length_counter.sv
// Channel length counter: table load, halt, half-frame decrement and
// channel-enable gating. Shared by triangle, pulse and noise channels.
module apu_length_counter
    import apu_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 load,
    input  logic [LEN_IDX_W-1:0] loadIdx,
    input  logic                 halt,
    input  logic                 halfFrame,
    output logic                 active
);

    logic [LEN_W-1:0] lenCnt;
    logic [LEN_W-1:0] lenNext;

    // Disable beats load, load beats the half-frame decrement.
    always_comb begin
        lenNext = lenCnt;
        if (!en) begin
            lenNext = '0;
        end else if (load) begin
            lenNext = LEN_W'(LEN_TABLE[loadIdx]);
        end else if (halfFrame && (lenCnt != '0) && !halt) begin
            lenNext = lenCnt - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lenCnt <= '0;
            active <= 1'b0;
        end else begin
            lenCnt <= lenNext;
            active <= (lenNext != '0);
        end
    end

endmodule

// File: rtl/apu_triangle_channel.sv
// APU triangle channel: period timer, linear counter, length counter and
// a 32-step up/down sequencer producing the mixer sample.
module apu_triangle_channel
    import apu_pkg::*;
#(
    parameter int unsigned TIMER_W         = TIMER_W_DEF,
    parameter int unsigned LIN_W           = LIN_W_DEF,
    parameter int unsigned LEN_W           = LEN_W_DEF,
    parameter int unsigned OUT_W           = OUT_W_DEF,
    parameter bit          MUTE_ULTRASONIC = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   timer_tick,
    input  logic                   quarter_frame,
    input  logic                   half_frame,
    input  logic                   chan_en,
    apu_triangle_channel_if.slave  regBus,
    output logic [OUT_W-1:0]       sample,
    output logic [OUT_W:0]         seq_step,
    output logic                   length_active
);

    localparam int unsigned HI_W  = TIMER_W - 8;
    localparam int unsigned SEQ_W = OUT_W + 1;

    logic               wrLinear, wrTimerLo, wrTimerHi;
    logic               control, reloadFlag, stepEn, stepDly;
    logic [LIN_W-1:0]   linReload, linear;
    logic [TIMER_W-1:0] period, timerCnt;

    always_comb begin
        wrLinear  = regBus.reg_we && (regBus.reg_addr == REG_LINEAR);
        wrTimerLo = regBus.reg_we && (regBus.reg_addr == REG_TIMER_LO);
        wrTimerHi = regBus.reg_we && (regBus.reg_addr == REG_TIMER_HI);
        stepEn    = timer_tick && (timerCnt == '0) && (linear != '0) && length_active
                    && !(MUTE_ULTRASONIC && (period < TIMER_W'(2)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            control   <= 1'b0;
            linReload <= '0;
            period    <= '0;
        end else begin
            if (wrLinear) begin
                control   <= regBus.reg_wdata[7];
                linReload <= regBus.reg_wdata[LIN_W-1:0];
            end
            if (wrTimerLo) period[7:0] <= regBus.reg_wdata;
            if (wrTimerHi) period[TIMER_W-1:8] <= regBus.reg_wdata[HI_W-1:0];
        end
    end

    // A byte-3 write sets the reload flag after this quarter frame has used the old one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            linear     <= '0;
            reloadFlag <= 1'b0;
        end else begin
            if (quarter_frame) begin
                if (reloadFlag) begin
                    linear <= linReload;
                end else if (linear != '0) begin
                    linear <= linear - LIN_W'(1);
                end
                if (!control) reloadFlag <= 1'b0;
            end
            if (wrTimerHi) reloadFlag <= 1'b1;
        end
    end

    // Sample follows seq_step one cycle after each step; it holds while muted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timerCnt <= '0;
            seq_step <= '0;
            stepDly  <= 1'b0;
            sample   <= '0;
        end else begin
            if (timer_tick) begin
                timerCnt <= (timerCnt == '0) ? period : timerCnt - TIMER_W'(1);
            end
            if (stepEn) seq_step <= seq_step + SEQ_W'(1);
            stepDly <= stepEn;
            if (stepDly) begin
                sample <= seq_step[OUT_W] ? seq_step[OUT_W-1:0] : ~seq_step[OUT_W-1:0];
            end
        end
    end

    apu_length_counter #(.LEN_W(LEN_W)) lengthCounter (
        .clk       (clk),
        .rstn      (rstn),
        .en        (chan_en),
        .load      (wrTimerHi),
        .loadIdx   (regBus.reg_wdata[7:3]),
        .halt      (control),
        .halfFrame (half_frame),
        .active    (length_active)
    );

endmodule

// File: tb/tb_apu_triangle_channel.sv
// Scoreboard bench for the triangle channel: two instances (ultrasonic mute
// on/off) share stimulus and are compared against a behavioural model.
module tb_apu_triangle_channel;

    localparam int SEQ_STEPS = 32;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic timer_tick = 1'b0;
    logic quarter_frame = 1'b0;
    logic half_frame = 1'b0;
    logic chan_en = 1'b0;

    logic [3:0] sampleM, sampleU;
    logic [4:0] stepM, stepU;
    logic       actM, actU;

    apu_triangle_channel_if bus ();

    apu_triangle_channel #(.MUTE_ULTRASONIC(1'b1)) dut (
        .clk(clk), .rstn(rstn), .timer_tick(timer_tick), .quarter_frame(quarter_frame),
        .half_frame(half_frame), .chan_en(chan_en), .regBus(bus),
        .sample(sampleM), .seq_step(stepM), .length_active(actM)
    );

    apu_triangle_channel #(.MUTE_ULTRASONIC(1'b0)) dutU (
        .clk(clk), .rstn(rstn), .timer_tick(timer_tick), .quarter_frame(quarter_frame),
        .half_frame(half_frame), .chan_en(chan_en), .regBus(bus),
        .sample(sampleU), .seq_step(stepU), .length_active(actU)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] smp0;
        logic [3:0] smp1;
        logic [4:0] stp0;
        logic [4:0] stp1;
        logic       act;
    } exp_t;

    exp_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mPeriod, mTimer, mLin, mLinReload, mLen;
    bit mCtrl, mReloadFlag;
    int mSeq[2];
    int mSmp[2];
    bit mStepPrev[2];
    int muteFlag[2] = '{1, 0};
    int lenTab[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int ampOf(int s);
        return (s < SEQ_STEPS / 2) ? (SEQ_STEPS / 2 - 1 - s) : (s - SEQ_STEPS / 2);
    endfunction

    function automatic void modelReset();
        mPeriod = 0; mTimer = 0; mLin = 0; mLinReload = 0; mLen = 0;
        mCtrl = 0; mReloadFlag = 0;
        for (int d = 0; d < 2; d++) begin
            mSeq[d] = 0; mSmp[d] = 0; mStepPrev[d] = 0;
        end
    endfunction

    // One clock of the channel; every decision uses pre-edge state, writes land last.
    function automatic void modelStep(bit we, bit [1:0] addr, bit [7:0] wd,
                                      bit tick, bit qf, bit hf, bit en);
        bit stepNow[2];
        stepNow[0] = 0;
        stepNow[1] = 0;
        if (tick) begin
            if (mTimer == 0) begin
                for (int d = 0; d < 2; d++)
                    stepNow[d] = (mLin != 0) && (mLen != 0) && !(muteFlag[d] != 0 && mPeriod < 2);
                mTimer = mPeriod;
            end else begin
                mTimer = mTimer - 1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (mStepPrev[d]) mSmp[d] = ampOf(mSeq[d]);
            if (stepNow[d]) mSeq[d] = (mSeq[d] + 1) % SEQ_STEPS;
            mStepPrev[d] = stepNow[d];
        end
        if (qf) begin
            if (mReloadFlag) mLin = mLinReload;
            else if (mLin > 0) mLin = mLin - 1;
            if (!mCtrl) mReloadFlag = 0;
        end
        if (!en) mLen = 0;
        else if (we && addr == 2'd3) mLen = lenTab[wd / 8];
        else if (hf && mLen > 0 && !mCtrl) mLen = mLen - 1;
        if (we) begin
            case (addr)
                2'd0: begin mCtrl = wd[7]; mLinReload = wd % 128; end
                2'd2: mPeriod = (mPeriod / 256) * 256 + wd;
                2'd3: begin mPeriod = (wd % 8) * 256 + (mPeriod % 256); mReloadFlag = 1; end
                default: ;
            endcase
        end
    endfunction

    task automatic cycle(bit we, bit [1:0] addr, bit [7:0] wd, bit tick, bit qf, bit hf);
        exp_t e;
        bus.reg_we = we; bus.reg_addr = addr; bus.reg_wdata = wd;
        timer_tick = tick; quarter_frame = qf; half_frame = hf;
        @(posedge clk);
        #1;
        modelStep(we, addr, wd, tick, qf, hf, chan_en);
        e.smp0 = 4'(mSmp[0]); e.smp1 = 4'(mSmp[1]);
        e.stp0 = 5'(mSeq[0]); e.stp1 = 5'(mSeq[1]);
        e.act  = (mLen != 0);
        expQ.push_back(e);
    endtask

    task automatic ticks(int n);
        repeat (n) cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkZero(string tag);
        check({tag, "_sample_mute"}, int'(sampleM), 0);
        check({tag, "_step_mute"},   int'(stepM),   0);
        check({tag, "_len_mute"},    int'(actM),    0);
        check({tag, "_sample_us"},   int'(sampleU), 0);
        check({tag, "_step_us"},     int'(stepU),   0);
        check({tag, "_len_us"},      int'(actU),    0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("sample_mute", int'(sampleM), int'(e.smp0));
            check("sample_us",   int'(sampleU), int'(e.smp1));
            check("step_mute",   int'(stepM),   int'(e.stp0));
            check("step_us",     int'(stepU),   int'(e.stp1));
            check("len_mute",    int'(actM),    int'(e.act));
            check("len_us",      int'(actU),    int'(e.act));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit [1:0] ra;
        bit [7:0] rd;
        bus.reg_we = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 8'h00;
        modelReset();
        #1 rstn = 1'b0;
        #2 checkZero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Idle channel: no writes, sequencer must stay put
        ticks(100);

        // Control set, period 3, length index 1, linear 1
        chan_en = 1'b1;
        cycle(1'b1, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        ticks(140);

        // Control clear: linear counts 1 -> 0 and the sequencer freezes
        cycle(1'b1, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        ticks(20);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        ticks(40);

        // Length 2 runs out after two half frames
        cycle(1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h18, 1'b0, 1'b0, 1'b0);
        ticks(8);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        ticks(4);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        ticks(8);

        // Period 1: muted instance freezes, the other steps every 2 ticks
        cycle(1'b1, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 8'h01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        ticks(40);

        // Coincident events and disabled-channel loads
        cycle(1'b1, 2'd0, 8'h05, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h18, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 2'd3, 8'h28, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 2'd0, 8'h87, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        ticks(6);
        chan_en = 1'b0;
        cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h08, 1'b1, 1'b0, 1'b0);
        ticks(4);
        chan_en = 1'b1;
        cycle(1'b1, 2'd1, 8'hFF, 1'b1, 1'b0, 1'b0);
        ticks(4);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            ra = 2'($urandom_range(0, 3));
            rd = 8'($urandom_range(0, 255));
            if (ra == 2'd2) rd = 8'($urandom_range(0, 6));
            if (ra == 2'd3 && $urandom_range(0, 3) != 0) rd = rd & 8'hF8;
            if ($urandom_range(0, 63) == 0) chan_en = ~chan_en;
            cycle($urandom_range(0, 7) == 0, ra, rd, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end

        // Mid-wave asynchronous reset
        chan_en = 1'b1;
        cycle(1'b1, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        ticks(30);
        cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1 checkZero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        rstn = 1'b1;
        ticks(20);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_triangle_channel.md
Name: apu_triangle_channel

Overview:
Parametrised triangle-wave channel for the APU. It generates the full waveform, not just a period divider: an 11-bit period timer, a linear counter, a length counter and a 32-step sequencer producing a 4-bit sample. It is programmed through a 4-byte register window and clocked by the APU frame sequencer's quarter-frame and half-frame strobes. Its output feeds the APU mixer beside the pulse and noise channels.

Parameters:
TIMER_W, 11, period timer width; period = {byte3[TIMER_W-9:0], byte2}.
LIN_W, 7, linear counter / reload value width (byte0[LIN_W-1:0]).
LEN_W, 8, length counter width.
OUT_W, 4, sample width; sequencer depth SEQ_STEPS = 2^(OUT_W+1).
MUTE_ULTRASONIC, 1, when 1 the sequencer freezes while period < 2.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
timer_tick  in  1  one-cycle enable; timer decrements once per pulse
quarter_frame  in  1  one-cycle linear-counter clock strobe
half_frame  in  1  one-cycle length-counter clock strobe
chan_en  in  1  channel enable from the APU status register
reg_we  in  1  register write strobe
reg_addr  in  2  byte select 0..3 (1 unused)
reg_wdata  in  8  write data
sample  out  OUT_W  current sequencer amplitude, registered
seq_step  out  OUT_W+1  current sequencer index
length_active  out  1  length counter != 0 (status readback)

Behaviour:
- Reset (async, rstn=0): all registers 0. sample=0, seq_step=0, length_active=0, control flag=0, reload flag=0.
- Byte 0 write: control/halt flag <= wdata[7]; lin_reload <= wdata[LIN_W-1:0].
- Byte 2 write: period[7:0] <= wdata.
- Byte 3 write: period high bits <= wdata[TIMER_W-9:0]. Reload flag <= 1. If chan_en=1, length <= LEN_TABLE[wdata[7:3]]. The timer counter is not reset.
- Byte 1 write: ignored.
- Timer, evaluated on timer_tick:
  - If timer_cnt == 0: timer_cnt <= period, and the sequencer steps.
  - Otherwise: timer_cnt decrements.
- Sequencer step condition: linear != 0, length != 0, and not (MUTE_ULTRASONIC and period < 2).
  - seq_step wraps from SEQ_STEPS-1 to 0.
  - If no step occurs, seq_step holds; the output is never forced to 0.
- sample = (seq_step < SEQ_STEPS/2) ? (SEQ_STEPS/2-1 - seq_step) : (seq_step - SEQ_STEPS/2). It is registered, so it updates one cycle after seq_step changes.
- Quarter frame:
  - If reload flag = 1: linear <= lin_reload.
  - Else if linear != 0: linear decrements.
  - Then, if control = 0, reload flag <= 0.
- Half frame: if length != 0 and control = 0, length decrements. It saturates at 0.
- chan_en=0: length forced to 0 every cycle; byte-3 length loads are discarded.
- Simultaneous events:
  - Byte-3 write with half_frame: the load wins and no decrement occurs that cycle.
  - Byte-3 write with quarter_frame: the linear logic sees the old reload flag; the new flag acts at the next quarter frame.
  - Byte-0 write with quarter_frame: the linear logic uses the old lin_reload and control values.
- Reset mid-operation returns to the reset state immediately. No pending write is retained.

Decomposition:
- Package apu_pkg:
  - LEN_TABLE, the 32-entry length lookup: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Register address constants.
  - Default widths.
- Sub-module apu_length_counter holds length load, halt, decrement and enable gating. It is reused by the pulse and noise channels.

Test Plan:
- Reset release, no writes, 100 timer_ticks -> sample=0, seq_step=0, length_active=0.
- chan_en=1; byte0=0x81; byte2=0x03; byte3=0x08 (index 1); one quarter_frame; timer_tick every cycle -> length=254, linear=1, seq_step advances every 4 ticks; sample sequence 15,14,...,0,0,1,...,15; wraps after 128 ticks.
- Same setup with byte0=0x01 (control=0); two quarter_frames -> linear 1 then 0; sequencer freezes, and sample holds its last value.
- byte0=0x00; byte3=0x18 (index 3, length 2); two half_frames -> length_active goes 1->1->0; sequencer stops.
- byte2=0x01 (period 1) with MUTE_ULTRASONIC=1 -> seq_step constant; with MUTE_ULTRASONIC=0 -> advances every 2 ticks.
- Byte-3 write coincident with half_frame -> length = table value, not table-1. chan_en=0 then byte-3 write -> length stays 0. rstn low mid-wave -> all outputs 0 asynchronously.
